// File: rtl/stream_to_binary_if.sv
// Handshake and result bundle between a stochastic stream source and the
// stream-to-binary converter. The master drives the stream, the slave reports results.
interface stream_to_binary_if #(
  parameter int WINDOW_LOG2 = 8
);
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam int VAL_W = WINDOW_LOG2 + 2;

  logic                    start;
  logic                    abort;
  logic                    bit_in;
  logic                    busy;
  logic                    done;
  logic        [CNT_W-1:0] count_out;
  logic signed [VAL_W-1:0] value_out;

  modport master (
    output start, abort, bit_in,
    input  busy, done, count_out, value_out
  );

  modport slave (
    input  start, abort, bit_in,
    output busy, done, count_out, value_out
  );
endinterface

// File: rtl/stream_to_binary.sv
// Counts ones in a stochastic bitstream over 2^WINDOW_LOG2 cycles and reports
// both the unipolar count and the bipolar value 2*count - 2^WINDOW_LOG2.
module stream_to_binary #(
  parameter  int WINDOW_LOG2 = 8,
  localparam int CNT_W       = WINDOW_LOG2 + 1,
  localparam int VAL_W       = WINDOW_LOG2 + 2
) (
  input  logic              clk,
  input  logic              reset,
  stream_to_binary_if.slave bus
);

  localparam logic [VAL_W-1:0] HALF = VAL_W'(1) << WINDOW_LOG2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic        [CNT_W-1:0] r_acc;
  logic  [WINDOW_LOG2-1:0] r_cnt;
  logic        [CNT_W-1:0] r_count_out;
  logic signed [VAL_W-1:0] r_value_out;
  logic        [CNT_W-1:0] w_acc_sum;

  // Doubling fits VAL_W unsigned; the modular subtraction lands on the exact
  // two's-complement result because the true value is always in range.
  function automatic logic signed [VAL_W-1:0] to_bipolar(input logic [CNT_W-1:0] cnt);
    return $signed({cnt, 1'b0} - HALF);
  endfunction

  assign w_acc_sum = r_acc + CNT_W'(bus.bit_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Abort outranks window completion on the final sample cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = ACCUM;
      ACCUM: begin
        if (bus.abort)   w_next = IDLE;
        else if (&r_cnt) w_next = DONE;
      end
      DONE:    w_next = (bus.start && !bus.abort) ? ACCUM : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_count_out <= '0;
      r_value_out <= to_bipolar('0);
    end else begin
      if (r_state != ACCUM && w_next == ACCUM) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == ACCUM) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + WINDOW_LOG2'(1);
      end
      if (r_state == ACCUM && w_next == DONE) begin
        r_count_out <= w_acc_sum;
        r_value_out <= to_bipolar(w_acc_sum);
      end
    end
  end

  assign bus.busy      = (r_state == ACCUM);
  assign bus.done      = (r_state == DONE);
  assign bus.count_out = r_count_out;
  assign bus.value_out = r_value_out;

endmodule

// File: tb/tb_stream_to_binary.sv
// Directed bench for stream_to_binary with a 16-cycle window; expected counts
// and bipolar values are worked out by hand for each stimulus pattern.
module tb_stream_to_binary;

  localparam int WL2 = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  stream_to_binary_if #(.WINDOW_LOG2(WL2)) bus ();

  stream_to_binary #(.WINDOW_LOG2(WL2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle, feed bits MSB first in cycles 1..16, check DONE
  // in cycle 17. chain leaves the DUT in DONE so the next window follows at once.
  task automatic window(input string tag, input logic [15:0] bits, input int exp_cnt,
                        input int exp_val, input bit chain, input int pa, input int pb);
    int bad;
    bad = 0;
    bus.start  = 1'b1;
    bus.bit_in = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (!bus.busy || bus.done) bad++;
      bus.start  = (c == pa) || (c == pb);
      bus.bit_in = bits[16-c];
      tick();
    end
    bus.start = 1'b0;
    chk({tag, "_busy"}, bad, 0);
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_done_busy"}, int'(bus.busy), 0);
    chk({tag, "_count"}, int'(bus.count_out), exp_cnt);
    chk({tag, "_value"}, int'(bus.value_out), exp_val);
    if (!chain) begin
      bus.bit_in = 1'b1;
      tick();
      chk({tag, "_idle_done"}, int'(bus.done), 0);
      chk({tag, "_idle_busy"}, int'(bus.busy), 0);
      chk({tag, "_hold_count"}, int'(bus.count_out), exp_cnt);
    end
  endtask

  initial begin
    int seen;
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.bit_in = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_count", int'(bus.count_out), 0);
    chk("rst_value", int'(bus.value_out), -16);
    reset = 1'b0;
    tick();

    window("ones", 16'hFFFF, 16, 16, 1'b0, 0, 0);
    window("zeros", 16'h0000, 0, -16, 1'b0, 0, 0);
    window("alt", 16'hAAAA, 8, 0, 1'b0, 0, 0);

    // back-to-back windows, then start+abort together in DONE
    window("b2b1", 16'hFFF0, 12, 8, 1'b1, 0, 0);
    window("b2b2", 16'hFFFF, 16, 16, 1'b1, 0, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("startabort_busy", int'(bus.busy), 0);
    tick();
    chk("startabort_idle", int'(bus.busy), 0);
    chk("startabort_count", int'(bus.count_out), 16);

    window("pulses", 16'h0007, 3, -10, 1'b0, 5, 10);

    // abort mid-window
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.bit_in = 1'b1;
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) seen++;
      tick();
    end
    chk("abort_nodone", seen, 0);
    chk("abort_count", int'(bus.count_out), 3);
    chk("abort_value", int'(bus.value_out), -10);

    // abort on the final sample cycle beats completion
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      bus.bit_in = 1'b1;
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abortlast_done", int'(bus.done), 0);
    chk("abortlast_busy", int'(bus.busy), 0);
    chk("abortlast_count", int'(bus.count_out), 3);

    // asynchronous reset mid-window
    window("prime", 16'hFF00, 8, 0, 1'b0, 0, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.bit_in = 1'b1;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_count", int'(bus.count_out), 0);
    chk("midrst_value", int'(bus.value_out), -16);
    tick();
    reset = 1'b0;
    tick();

    window("edges", 16'h8001, 2, -12, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_to_binary.md
Name: stream_to_binary

Overview:
- Converts a serial stochastic bitstream, such as the output of the scaling add/subtract stages, back to a binary value.
- Counts the ones in `bit_in` over a fixed window of 2^WINDOW_LOG2 cycles.
- Reports two results when the window closes:
  - the unipolar count;
  - the signed bipolar value, 2*count - 2^WINDOW_LOG2.
- Sits at the end of a stochastic datapath, feeding a binary consumer or the testbench scoreboard.

Parameters:
- WINDOW_LOG2, 8, log2 of the window length in cycles; legal range 1..16.
- CNT_W, WINDOW_LOG2+1, width of the unipolar count (range 0..2^WINDOW_LOG2). Derived; not overridden.
- VAL_W, WINDOW_LOG2+2, width of the signed bipolar value (range -2^WINDOW_LOG2..+2^WINDOW_LOG2). Derived; not overridden.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a window; honoured only in IDLE or DONE.
- abort  input  1  aborts the current window; returns to IDLE with no done pulse.
- bit_in  input  1  stochastic bitstream; one bit is consumed per ACCUM cycle.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse; count_out and value_out are updated in the same cycle.
- count_out  output  CNT_W  number of ones seen in the last completed window.
- value_out  output  VAL_W  two's-complement value 2*count_out - 2^WINDOW_LOG2.

Behaviour:
- Reset:
  - state IDLE; busy=0, done=0, count_out=0;
  - value_out = -2^WINDOW_LOG2, consistent with count 0;
  - internal accumulator and cycle counter cleared.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - start=1 -> ACCUM; accumulator and cycle counter are cleared.
  - bit_in is not sampled in the start cycle.
- ACCUM:
  - Each cycle adds bit_in to the accumulator and increments the cycle counter.
  - After exactly 2^WINDOW_LOG2 samples, the next state is DONE.
  - The final sample is included in the result.
- DONE (one cycle):
  - done=1; count_out and value_out show the new result in this cycle (registered on the DONE entry edge).
  - start=1 -> ACCUM (back-to-back windows with no gap cycle); otherwise -> IDLE.
- Latency: with start high in cycle 0, samples are taken in cycles 1..2^WINDOW_LOG2 and done is high in cycle 2^WINDOW_LOG2+1.
- start while in ACCUM is ignored; the window is neither restarted nor extended.
- abort:
  - In ACCUM: -> IDLE next cycle; count_out and value_out keep the previous result; no done pulse.
  - abort has priority over window completion in the last sample cycle.
  - In IDLE or DONE: no effect, except that abort and start together in DONE -> IDLE.
- Accumulator overflow: none. The accumulator is CNT_W wide, and all-ones over a full window yields exactly 2^WINDOW_LOG2.
- value_out is computed as (count << 1) minus the constant 2^WINDOW_LOG2, sign-extended into VAL_W. Results must be exact at both extremes.
- Outputs hold their value between done pulses.
- bit_in is ignored outside ACCUM.
- reset asserted mid-window: immediate return to reset values; the partial result is discarded.

Test Plan:
- WINDOW_LOG2=4; start, then bit_in=1 for 16 cycles -> done in cycle 17; count_out=16, value_out=+16; busy high in cycles 1..16.
- bit_in=0 for the full window -> count_out=0, value_out=-16.
- Alternating 1,0 over the window -> count_out=8, value_out=0.
- 12 ones then 4 zeros, with start held high through DONE -> count_out=12, value_out=+8.
  - A second window begins with no idle cycle.
  - A second window of all ones gives 16 / +16.
- start pulses at cycles 5 and 10 of a window -> ignored; done still in cycle 17.
- abort at cycle 9 -> IDLE, no done pulse, previous outputs held.
- reset at cycle 9 -> all outputs return to reset values (count_out=0, value_out=-16).
